// File: rtl/lzrw1_item_unpacker.sv
// LZRW1 byte-stream front end: splits control words and literal/copy items into 16-bit items.
// Optional macro LZRW1_UNPACK_LEN_CHECK_EN drops copy items with zero length or zero offset.
module lzrw1_item_unpacker #(
    parameter int unsigned GROUP_SIZE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] item_data,
    output logic        item_is_copy,
    output logic        item_valid,
    input  logic        item_busy,
    output logic        stream_done,
    output logic        format_error
);

    typedef enum logic [2:0] {CTRL_LO, CTRL_HI, ITEM_B0, ITEM_B1, EMIT} state_t;

    localparam logic [3:0] LAST_IDX = 4'(GROUP_SIZE - 1);

    state_t      state, state_next;
    logic [15:0] ctrl;
    logic [3:0]  item_idx;
    logic [7:0]  byte0;
    logic        last_seen;
    logic [15:0] data_q;
    logic        copy_q;
    logic        done_q;
    logic        err_q;

    logic take, give, bad_copy;
    logic ld_ctrl_lo, ld_ctrl_hi, ld_b0, ld_lit, ld_copy;
    logic idx_inc, last_set, done_set, err_set;

    assign in_ready     = (state != EMIT) && !reset;
    assign take         = in_valid && in_ready;
    assign give         = (state == EMIT) && !item_busy;
    assign item_valid   = (state == EMIT);
    assign item_data    = data_q;
    assign item_is_copy = copy_q;
    assign stream_done  = done_q;
    assign format_error = err_q;

`ifdef LZRW1_UNPACK_LEN_CHECK_EN
    assign bad_copy = (byte0[7:4] == 4'h0) || ({byte0[3:0], in_byte} == 12'h000);
`else
    assign bad_copy = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ld_ctrl_lo = 1'b0;
        ld_ctrl_hi = 1'b0;
        ld_b0      = 1'b0;
        ld_lit     = 1'b0;
        ld_copy    = 1'b0;
        idx_inc    = 1'b0;
        last_set   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            CTRL_LO: if (take) begin
                if (in_last) begin
                    err_set  = 1'b1;
                    done_set = 1'b1;
                end else begin
                    ld_ctrl_lo = 1'b1;
                    state_next = CTRL_HI;
                end
            end
            CTRL_HI: if (take) begin
                if (in_last) begin
                    err_set    = 1'b1;
                    done_set   = 1'b1;
                    state_next = CTRL_LO;
                end else begin
                    ld_ctrl_hi = 1'b1;
                    state_next = ITEM_B0;
                end
            end
            ITEM_B0: if (take) begin
                if (!ctrl[item_idx]) begin
                    ld_lit     = 1'b1;
                    last_set   = in_last;
                    state_next = EMIT;
                end else if (in_last) begin
                    err_set    = 1'b1;
                    done_set   = 1'b1;
                    state_next = CTRL_LO;
                end else begin
                    ld_b0      = 1'b1;
                    state_next = ITEM_B1;
                end
            end
            ITEM_B1: if (take) begin
                if (bad_copy) begin
                    // Dropped copy still occupies its slot: advance exactly as after an EMIT.
                    err_set = 1'b1;
                    if (in_last) begin
                        done_set   = 1'b1;
                        state_next = CTRL_LO;
                    end else if (item_idx == LAST_IDX) begin
                        state_next = CTRL_LO;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = ITEM_B0;
                    end
                end else begin
                    ld_copy    = 1'b1;
                    last_set   = in_last;
                    state_next = EMIT;
                end
            end
            EMIT: if (give) begin
                if (last_seen) begin
                    done_set   = 1'b1;
                    state_next = CTRL_LO;
                end else if (item_idx == LAST_IDX) begin
                    state_next = CTRL_LO;
                end else begin
                    idx_inc    = 1'b1;
                    state_next = ITEM_B0;
                end
            end
            default: state_next = CTRL_LO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= CTRL_LO;
            ctrl      <= '0;
            item_idx  <= '0;
            byte0     <= '0;
            last_seen <= 1'b0;
            data_q    <= '0;
            copy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_set;
            err_q  <= err_q | err_set;
            if (ld_ctrl_lo) ctrl[7:0] <= in_byte;
            if (ld_ctrl_hi) begin
                ctrl[15:8] <= in_byte;
                item_idx   <= '0;
            end else if (idx_inc) begin
                item_idx <= item_idx + 4'd1;
            end
            if (ld_b0) byte0 <= in_byte;
            if (state_next == CTRL_LO) last_seen <= 1'b0;
            else if (last_set)         last_seen <= 1'b1;
            if (ld_lit) begin
                data_q <= {8'h00, in_byte};
                copy_q <= 1'b0;
            end else if (ld_copy) begin
                data_q <= {byte0, in_byte};
                copy_q <= 1'b1;
            end
        end
    end

endmodule
